// File: rtl/dffpll_pkg.sv
// Shared definitions for the dual-FF PFD PLL datapath: FSM encodings,
// saturation helpers and the default NCO centre word.
package dffpll_pkg;

    // Loop-filter sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_INTEG = 2'd1;
    localparam logic [1:0] ST_SUM   = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    // Free-running NCO/DCO control word
    localparam logic [31:0] DEFAULT_CENTER = 32'h4000_0000;

    // Working width of the helpers; callers extend into it and truncate back
    localparam int MAXW = 128;

    // Clamp a signed value into the signed range of a w-bit word
    function automatic logic signed [MAXW-1:0] sat_signed(
        input logic signed [MAXW-1:0] x,
        input int                     w
    );
        logic signed [MAXW-1:0] one;
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        one = 1;
        hi  = (one <<< (w - 1)) - one;
        lo  = -(one <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^w-1]
    function automatic logic [MAXW-1:0] clamp_unsigned(
        input logic signed [MAXW-1:0] x,
        input int                     w
    );
        logic signed [MAXW-1:0] one;
        logic signed [MAXW-1:0] hi;
        one = 1;
        hi  = (one <<< w) - one;
        if (x < 0) begin
            return '0;
        end else if (x > hi) begin
            return hi;
        end
        return x;
    endfunction

endpackage

// File: rtl/pll_loop_filter.sv
// Proportional-integral loop filter for the dual-FF PFD PLL. One shared
// adder is time-multiplexed by a 4-state sequencer: integrate, form the
// P+I sum, then re-centre and clamp into the unsigned NCO control word.
module pll_loop_filter
    import dffpll_pkg::*;
#(
    parameter int               WIDTH  = 24,
    parameter int               ACC_W  = 40,
    parameter int               KP_SH  = 8,
    parameter int               KI_SH  = 2,
    parameter int               OUT_SH = 8,
    parameter int               OUT_W  = 32,
    parameter logic [OUT_W-1:0] CENTER = OUT_W'(DEFAULT_CENTER)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    in_en,
    input  logic signed [WIDTH-1:0] in,
    output logic                    out_en,
    output logic [OUT_W-1:0]        out,
    output logic                    overrun
);

    // Adder width covers both the ACC_W+1 accumulation and the re-centring
    // of the output word without overflow.
    localparam int SUM_W = (ACC_W + 1 > OUT_W + 2) ? (ACC_W + 1) : (OUT_W + 2);

    logic [1:0]               state_q, state_d;
    logic signed [ACC_W-1:0]  e_q, e_d;
    logic signed [ACC_W-1:0]  integ_q, integ_d;
    logic signed [ACC_W:0]    s_q, s_d;
    logic [OUT_W-1:0]         out_q, out_d;
    logic                     out_en_q, out_en_d;
    logic                     overrun_q, overrun_d;

    logic signed [SUM_W-1:0]  op_a;
    logic signed [SUM_W-1:0]  op_b;
    logic signed [SUM_W-1:0]  sum;

    // Operand mux in front of the single shared adder
    always_comb begin
        op_a = SUM_W'(integ_q);
        op_b = SUM_W'(e_q) <<< KI_SH;
        case (state_q)
            ST_SUM: begin
                op_b = SUM_W'(e_q) <<< KP_SH;
            end
            ST_OUT: begin
                op_a = SUM_W'(CENTER);
                op_b = SUM_W'(s_q >>> OUT_SH);
            end
            default: begin
            end
        endcase
        sum = op_a + op_b;
    end

    // Sequencer and register updates; everything holds while en is low
    always_comb begin
        state_d   = state_q;
        e_d       = e_q;
        integ_d   = integ_q;
        s_d       = s_q;
        out_d     = out_q;
        out_en_d  = out_en_q;
        overrun_d = overrun_q;
        if (en) begin
            out_en_d = 1'b0;
            // Strobes arriving while a sample is in flight are lost
            if (in_en && (state_q != ST_IDLE)) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (in_en) begin
                        e_d     = ACC_W'(in);
                        state_d = ST_INTEG;
                    end
                end
                ST_INTEG: begin
                    integ_d = ACC_W'(sat_signed(MAXW'(sum), ACC_W));
                    state_d = ST_SUM;
                end
                ST_SUM: begin
                    s_d     = $signed(sum[ACC_W:0]);
                    state_d = ST_OUT;
                end
                ST_OUT: begin
                    out_d    = OUT_W'(clamp_unsigned(MAXW'(sum), OUT_W));
                    out_en_d = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            e_q       <= '0;
            integ_q   <= '0;
            s_q       <= '0;
            out_q     <= CENTER;
            out_en_q  <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            e_q       <= e_d;
            integ_q   <= integ_d;
            s_q       <= s_d;
            out_q     <= out_d;
            out_en_q  <= out_en_d;
            overrun_q <= overrun_d;
        end
    end

    assign out     = out_q;
    assign out_en  = out_en_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_pll_loop_filter.sv
// Bench for pll_loop_filter: four instances cover the default gains, a
// narrow integrator for saturation, and two centre words for output clamping.
module tb_pll_loop_filter;

    typedef struct {
        int          inst;
        logic [31:0] val;
    } exp_t;

    logic        clk;
    logic        rst_s [4];
    logic        en_s  [4];
    logic        ie_s  [4];
    logic [23:0] din   [4];
    logic        oen   [4];
    logic [31:0] dout  [4];
    logic        ovr   [4];
    logic [31:0] ctr   [4];

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;

    pll_loop_filter u0 (
        .clk(clk), .rst(rst_s[0]), .en(en_s[0]), .in_en(ie_s[0]), .in(din[0]),
        .out_en(oen[0]), .out(dout[0]), .overrun(ovr[0])
    );

    pll_loop_filter #(.ACC_W(28), .KP_SH(2)) u1 (
        .clk(clk), .rst(rst_s[1]), .en(en_s[1]), .in_en(ie_s[1]), .in(din[1]),
        .out_en(oen[1]), .out(dout[1]), .overrun(ovr[1])
    );

    pll_loop_filter #(.CENTER(32'h0000_0000)) u2 (
        .clk(clk), .rst(rst_s[2]), .en(en_s[2]), .in_en(ie_s[2]), .in(din[2]),
        .out_en(oen[2]), .out(dout[2]), .overrun(ovr[2])
    );

    pll_loop_filter #(.CENTER(32'hFFFF_FFF0)) u3 (
        .clk(clk), .rst(rst_s[3]), .en(en_s[3]), .in_en(ie_s[3]), .in(din[3]),
        .out_en(oen[3]), .out(dout[3]), .overrun(ovr[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset(input int i);
        rst_s[i] = 1'b1;
        tick();
        rst_s[i] = 1'b0;
    endtask

    // One strobe with full latency and pulse-width checks
    task automatic strobe(input int i, input logic [23:0] v, input logic [31:0] expv);
        q.push_back('{i, expv});
        ie_s[i] = 1'b1;
        din[i]  = v;
        tick();
        ie_s[i] = 1'b0;
        ticks(2);
        chk("lat_early", 64'(oen[i]), 64'd0);
        tick();
        chk("lat_k3", 64'(oen[i]), 64'd1);
        tick();
        chk("pulse_width", 64'(oen[i]), 64'd0);
    endtask

    // Monitor: every presented output is matched against the scoreboard
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (oen[i] === 1'b1) begin
                if (q.size() == 0) begin
                    chk("spurious_out_en", 64'(oen[i]), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_inst", 64'(i), 64'(e.inst));
                    chk("out_word", 64'(dout[i]), 64'(e.val));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ctr[0] = 32'h4000_0000;
        ctr[1] = 32'h4000_0000;
        ctr[2] = 32'h0000_0000;
        ctr[3] = 32'hFFFF_FFF0;
        for (int i = 0; i < 4; i++) begin
            rst_s[i] = 1'b1;
            en_s[i]  = 1'b1;
            ie_s[i]  = 1'b0;
            din[i]   = '0;
        end
        ticks(2);
        for (int i = 0; i < 4; i++) rst_s[i] = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            chk("rst_out", 64'(dout[i]), 64'(ctr[i]));
            chk("rst_out_en", 64'(oen[i]), 64'd0);
            chk("rst_overrun", 64'(ovr[i]), 64'd0);
        end

        // Basic P+I path on default gains
        strobe(0, 24'd4, 32'h4000_0004);
        chk("ovr_clean", 64'(ovr[0]), 64'd0);
        strobe(0, 24'd4, 32'h4000_0004);
        strobe(0, 24'hFFFF00, 32'h3FFF_FEFC);
        strobe(0, 24'd0, 32'h3FFF_FFFC);
        strobe(0, 24'd0, 32'h3FFF_FFFC);

        // Integrator saturation on the 28-bit accumulator
        do_reset(1);
        for (int n = 1; n <= 40; n++) begin
            logic [31:0] ev;
            case (n)
                1:       ev = 32'h4003_FFFF;
                2:       ev = 32'h4005_FFFF;
                3:       ev = 32'h4007_FFFF;
                default: ev = 32'h4009_FFFF;
            endcase
            strobe(1, 24'h7FFFFF, ev);
        end
        chk("sat_integ_max", {36'd0, u1.integ_q}, 64'h7FF_FFFF);
        strobe(1, 24'hFFFFFF, 32'h4007_FFFF);
        chk("sat_integ_dec", {36'd0, u1.integ_q}, 64'h7FF_FFFB);

        // Output clamps
        strobe(2, 24'h800000, 32'h0000_0000);
        strobe(3, 24'h7FFFFF, 32'hFFFF_FFFF);

        // Busy drop: strobes two cycles apart
        do_reset(0);
        q.push_back('{0, 32'h4000_0004});
        ie_s[0] = 1'b1; din[0] = 24'd4;
        tick();
        ie_s[0] = 1'b0;
        tick();
        ie_s[0] = 1'b1; din[0] = 24'h000100;
        tick();
        ie_s[0] = 1'b0;
        tick();
        chk("busy_out_en", 64'(oen[0]), 64'd1);
        chk("busy_overrun", 64'(ovr[0]), 64'd1);
        ticks(6);
        chk("busy_overrun_sticky", 64'(ovr[0]), 64'd1);
        do_reset(0);
        chk("busy_overrun_clr", 64'(ovr[0]), 64'd0);

        // Strobe on OUT->IDLE is dropped; strobe on the out_en cycle is taken
        q.push_back('{0, 32'h4000_0004});
        q.push_back('{0, 32'h4000_0104});
        ie_s[0] = 1'b1; din[0] = 24'd4;
        tick();
        ie_s[0] = 1'b0;
        ticks(2);
        ie_s[0] = 1'b1; din[0] = 24'h000200;
        tick();
        chk("b2b_first_out_en", 64'(oen[0]), 64'd1);
        chk("b2b_drop_overrun", 64'(ovr[0]), 64'd1);
        din[0] = 24'h000100;
        tick();
        ie_s[0] = 1'b0;
        ticks(2);
        chk("b2b_lat_early", 64'(oen[0]), 64'd0);
        tick();
        chk("b2b_second_out_en", 64'(oen[0]), 64'd1);
        tick();

        // en low for 5 cycles while in SUM
        do_reset(0);
        q.push_back('{0, 32'h4000_0004});
        ie_s[0] = 1'b1; din[0] = 24'd4;
        tick();
        ie_s[0] = 1'b0;
        tick();
        en_s[0] = 1'b0;
        ticks(5);
        chk("stall_held", 64'(oen[0]), 64'd0);
        en_s[0] = 1'b1;
        tick();
        chk("stall_lat_early", 64'(oen[0]), 64'd0);
        tick();
        chk("stall_lat_k8", 64'(oen[0]), 64'd1);
        tick();

        // in_en while en low is ignored
        en_s[0] = 1'b0;
        ie_s[0] = 1'b1; din[0] = 24'd4;
        ticks(3);
        ie_s[0] = 1'b0;
        en_s[0] = 1'b1;
        ticks(5);
        chk("en_low_no_overrun", 64'(ovr[0]), 64'd0);

        // Reset coincident with in_en wins
        rst_s[0] = 1'b1; ie_s[0] = 1'b1; din[0] = 24'h000100;
        tick();
        rst_s[0] = 1'b0; ie_s[0] = 1'b0;
        ticks(5);
        chk("rst_in_en_overrun", 64'(ovr[0]), 64'd0);
        chk("rst_in_en_out", 64'(dout[0]), 64'h4000_0000);

        // Reset mid-sequence aborts and clears the integrator
        strobe(0, 24'h000100, 32'h4000_0104);
        ie_s[0] = 1'b1; din[0] = 24'h000100;
        tick();
        ie_s[0] = 1'b0;
        rst_s[0] = 1'b1;
        tick();
        rst_s[0] = 1'b0;
        chk("abort_out", 64'(dout[0]), 64'h4000_0000);
        chk("abort_out_en", 64'(oen[0]), 64'd0);
        ticks(5);
        strobe(0, 24'h000100, 32'h4000_0104);

        ticks(3);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
